nn_sample_framer: RTL and testbench

User-logic stage between the axi_wrapper m_axis_data output (32-bit words, one I/Q sample pair per word) and the HLS neural-net layer input stream. It splits each word into two signed 16-bit samples, I first then Q. It frames the sample stream into fixed-length input vectors with tlast on the last sample of each vector. Vector length is programmable through the settings bus; it replaces the direct loopback wiring on the input side of the NoC block.

---
 rtl/nn_sample_framer.sv | 256 +++++++++++++++++++++++++
 tb/tb_nn_sample_framer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_sample_framer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : nn_sample_framer                                              |
// | Purpose  : Splits 32-bit {I,Q} words into two signed 16-bit samples      |
// |            (I first, then Q) and frames the sample stream into vectors   |
// |            of programmable length, with tlast on each vector's last      |
// |            sample.                                                       |
// | Ports    : ce_clk/ce_rst    clock, synchronous active-high reset         |
// |            set_stb/addr/data settings bus (vector length register)       |
// |            s_axis_*         32-bit word input stream                     |
// |            m_axis_*         16-bit sample output stream                  |
// |            frame_count      completed vectors (wraps)                    |
// |            mismatch_count   upstream packets ending mid-vector (sat.)    |
// | Options  : NN_FRAMER_PAD_EN - zero-pad a vector when the upstream packet |
// |            ends early, so each vector starts on an upstream packet start.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module nn_sample_framer #(
  parameter int FRAME_LEN_MAX = 64,
  parameter int SR_FRAME_LEN  = 130,
  parameter int SAMP_W        = 16
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [SAMP_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       frame_count,
  output logic [15:0]       mismatch_count
);

  localparam int               LEN_W       = $clog2(FRAME_LEN_MAX + 1);
  localparam logic [LEN_W-1:0] C_LEN_MAX   = LEN_W'(FRAME_LEN_MAX);
  localparam logic [15:0]      C_LEN_MAX16 = 16'(FRAME_LEN_MAX);
  localparam logic [7:0]       C_SR_ADDR   = 8'(SR_FRAME_LEN);
  localparam logic [LEN_W-1:0] C_ONE       = LEN_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_PAD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SAMP_W-1:0] tdata_q, tdata_d;
  logic [SAMP_W-1:0] qhold_q, qhold_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  act_len_q, act_len_d;
  logic [LEN_W-1:0]  pend_len_q, pend_len_d;
  logic [31:0]       frame_q, frame_d;
  logic [15:0]       mism_q, mism_d;
`ifdef NN_FRAMER_PAD_EN
  logic              pad_q, pad_d;
`endif

  logic              w_hs;
  logic              w_acc;
  logic              w_s_rdy;
  logic              w_last_next;
  logic              w_q_is_last;
  logic              w_mismatch;
  logic [15:0]       w_wr_val;
  logic              unused_set_bits;

  // Length must be even: bit 0 is dropped on write.
  assign w_wr_val        = {set_data[15:1], 1'b0};
  assign unused_set_bits = ^{set_data[31:16], set_data[0]};

  always_comb begin
    w_s_rdy = 1'b0;
    unique case (state_q)
      ST_IDLE: w_s_rdy = 1'b1;
`ifdef NN_FRAMER_PAD_EN
      ST_LO:   w_s_rdy = m_axis_tready & ~pad_q;
`else
      ST_LO:   w_s_rdy = m_axis_tready;
`endif
      default: w_s_rdy = 1'b0;
    endcase
  end

  assign w_hs  = tvalid_q & m_axis_tready;
  assign w_acc = s_axis_tvalid & w_s_rdy;

  always_comb begin
    // Pending length register (settings bus)
    pend_len_d = pend_len_q;
    if (set_stb && (set_addr == C_SR_ADDR) && (w_wr_val != 16'd0)) begin
      if (w_wr_val > C_LEN_MAX16) begin
        pend_len_d = C_LEN_MAX;
      end else begin
        pend_len_d = w_wr_val[LEN_W-1:0];
      end
    end

    // Length is latched only at a vector boundary: either the cycle the
    // previous vector's last sample leaves, or while idle at counter 0.
    // A vector's length is therefore fixed from its first sample onward.
    act_len_d = act_len_q;
    if ((w_hs && tlast_q) || ((state_q == ST_IDLE) && (cnt_q == '0))) begin
      act_len_d = pend_len_q;
    end

    // Sample counter / frame counter
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (w_hs) begin
      if (tlast_q) begin
        cnt_d   = '0;
        frame_d = frame_q + 32'd1;
      end else begin
        cnt_d = cnt_q + C_ONE;
      end
    end

    // cnt_d is the index of whatever sample is loaded next; an accepted
    // word's I lands on cnt_d and its Q on cnt_d+1.
    w_last_next = (cnt_d == (act_len_d - C_ONE));
    w_q_is_last = ((cnt_d + C_ONE) == (act_len_d - C_ONE));
    w_mismatch  = w_acc & s_axis_tlast & ~w_q_is_last;

    mism_d = mism_q;
    if (w_mismatch && (mism_q != 16'hFFFF)) begin
      mism_d = mism_q + 16'd1;
    end

`ifdef NN_FRAMER_PAD_EN
    pad_d = pad_q;
    if (w_mismatch) begin
      pad_d = 1'b1;
    end
`endif

    state_d  = state_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    qhold_d  = qhold_q;

    unique case (state_q)
      ST_IDLE: begin
        if (w_acc) begin
          state_d  = ST_HI;
          tvalid_d = 1'b1;
          tdata_d  = s_axis_tdata[SAMP_W +: SAMP_W];
          qhold_d  = s_axis_tdata[0 +: SAMP_W];
          tlast_d  = w_last_next;
        end
      end
      ST_HI: begin
        if (w_hs) begin
          state_d = ST_LO;
          tdata_d = qhold_q;
          tlast_d = w_last_next;
        end
      end
      ST_LO: begin
        if (w_hs) begin
`ifdef NN_FRAMER_PAD_EN
          if (pad_q) begin
            state_d = ST_PAD;
            tdata_d = '0;
            tlast_d = w_last_next;
            pad_d   = 1'b0;
          end else
`endif
          if (w_acc) begin
            state_d = ST_HI;
            tdata_d = s_axis_tdata[SAMP_W +: SAMP_W];
            qhold_d = s_axis_tdata[0 +: SAMP_W];
            tlast_d = w_last_next;
          end else begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
          end
        end
      end
      ST_PAD: begin
`ifdef NN_FRAMER_PAD_EN
        if (w_hs) begin
          if (tlast_q) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end else begin
            tlast_d = w_last_next;
          end
        end
`else
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
`endif
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state_q    <= ST_IDLE;
      tdata_q    <= '0;
      qhold_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      cnt_q      <= '0;
      act_len_q  <= C_LEN_MAX;
      pend_len_q <= C_LEN_MAX;
      frame_q    <= '0;
      mism_q     <= '0;
`ifdef NN_FRAMER_PAD_EN
      pad_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tdata_q    <= tdata_d;
      qhold_q    <= qhold_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      cnt_q      <= cnt_d;
      act_len_q  <= act_len_d;
      pend_len_q <= pend_len_d;
      frame_q    <= frame_d;
      mism_q     <= mism_d;
`ifdef NN_FRAMER_PAD_EN
      pad_q      <= pad_d;
`endif
    end
  end

  assign s_axis_tready  = w_s_rdy;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tvalid  = tvalid_q;
  assign frame_count    = frame_q;
  assign mismatch_count = mism_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_sample_framer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_nn_sample_framer                                           |
// | Purpose  : Self-checking bench for nn_sample_framer. Hand-written cycle  |
// |            tables for latency/reset, a length-register vector table,     |
// |            and randomized streams checked against a sample-list model.  |
// | Options  : NN_FRAMER_PAD_EN selects the padding reference behaviour.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_nn_sample_framer;

  localparam int FRAME_LEN_MAX = 64;
  localparam int SR_FRAME_LEN  = 130;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [31:0] frame_count;
  logic [15:0] mismatch_count;

  always #5 ce_clk = ~ce_clk;

  nn_sample_framer #(
    .FRAME_LEN_MAX (FRAME_LEN_MAX),
    .SR_FRAME_LEN  (SR_FRAME_LEN),
    .SAMP_W        (16)
  ) dut (
    .ce_clk         (ce_clk),
    .ce_rst         (ce_rst),
    .set_stb        (set_stb),
    .set_addr       (set_addr),
    .set_data       (set_data),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .frame_count    (frame_count),
    .mismatch_count (mismatch_count)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } samp_t;

  samp_t       exp_q[$];
  samp_t       got_q[$];
  logic [31:0] src_d[$];
  logic        src_l[$];

  // Reference model state: sample position in vector, lengths, counters
  int m_cnt, m_len, m_pend, exp_frames, exp_mism;

  int n_checks = 0;
  int n_fail   = 0;

  logic        prev_stall = 1'b0;
  logic [15:0] prev_d = '0;
  logic        prev_l = 1'b0;
  logic [15:0] last_q_samp = '0;
  logic        tog = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_sample(input logic [15:0] d);
    samp_t s;
    if (m_cnt == 0) m_len = m_pend;
    s.d = d;
    s.l = (m_cnt == m_len - 1);
    exp_q.push_back(s);
    if (m_cnt == m_len - 1) begin
      m_cnt = 0;
      exp_frames++;
    end else begin
      m_cnt++;
    end
  endfunction

  function automatic void model_word(input logic [31:0] w, input logic l);
    int  eff;
    bit  mis;
    eff = (m_cnt == 0) ? m_pend : m_len;
    mis = l && ((m_cnt + 1) != (eff - 1));
    push_sample(w[31:16]);
    push_sample(w[15:0]);
    if (mis) begin
      exp_mism++;
`ifdef NN_FRAMER_PAD_EN
      while (m_cnt != 0) push_sample(16'h0000);
`endif
    end
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_len = FRAME_LEN_MAX; m_pend = FRAME_LEN_MAX;
    exp_frames = 0; exp_mism = 0;
    exp_q.delete(); got_q.delete(); src_d.delete(); src_l.delete();
    prev_stall = 1'b0;
  endfunction

  function automatic void queue_word(input logic [31:0] w, input logic l);
    src_d.push_back(w);
    src_l.push_back(l);
    model_word(w, l);
  endfunction

  // ---------------- drivers (enter/leave at posedge+1) ----------------
  task automatic do_reset();
    ce_rst = 1'b1; s_axis_tvalid = 1'b0; set_stb = 1'b0; m_axis_tready = 1'b0;
    @(posedge ce_clk); #1;
    ce_rst = 1'b0;
    model_reset();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge ce_clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic cycle(input int rmode, input bit gaps);
    bit    acc;
    samp_t s;
    case (rmode)
      0: m_axis_tready = 1'b1;
      1: begin m_axis_tready = tog; tog = ~tog; end
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
    if (!s_axis_tvalid && src_d.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
      s_axis_tdata  = src_d[0];
      s_axis_tlast  = src_l[0];
      s_axis_tvalid = 1'b1;
    end
    @(negedge ce_clk);
    if (prev_stall) begin
      check("stall_valid_held", {31'd0, m_axis_tvalid}, 32'd1);
      check("stall_data_held", {16'd0, m_axis_tdata}, {16'd0, prev_d});
      check("stall_last_held", {31'd0, m_axis_tlast}, {31'd0, prev_l});
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_d     = m_axis_tdata;
    prev_l     = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) begin
      s.d = m_axis_tdata;
      s.l = m_axis_tlast;
      got_q.push_back(s);
    end
    // Input is only taken while the Q sample of the previous word is shown.
    if (s_axis_tready && m_axis_tvalid)
      check("in_ready_only_on_q", {16'd0, m_axis_tdata}, {16'd0, last_q_samp});
    acc = s_axis_tvalid && s_axis_tready;
    @(posedge ce_clk); #1;
    if (acc) begin
      last_q_samp = src_d[0][15:0];
      void'(src_d.pop_front());
      void'(src_l.pop_front());
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic run_stream(input int rmode, input bit gaps);
    int cyc = 0;
    int n;
    while (!(src_d.size() == 0 && !s_axis_tvalid && got_q.size() >= exp_q.size()) && cyc < 4000) begin
      cycle(rmode, gaps);
      cyc++;
    end
    if (cyc >= 4000) begin
      n_checks++; n_fail++;
      $display("FAIL stream_timeout: got %0d of %0d samples", got_q.size(), exp_q.size());
    end
    repeat (4) cycle(0, 1'b0);
    check("stream_len", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("sample_data", {16'd0, got_q[i].d}, {16'd0, exp_q[i].d});
      check("sample_last", {31'd0, got_q[i].l}, {31'd0, exp_q[i].l});
    end
    check("frame_count", frame_count, exp_frames);
    check("mismatch_count", {16'd0, mismatch_count}, exp_mism);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tables ----------------
  typedef struct {
    bit          sv;
    logic [31:0] sd;
    bit          e_srdy;
    bit          e_vld;
    logic [15:0] e_d;
    bit          e_l;
  } hand_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          exp_len;
  } len_vec_t;

  hand_t    hv[6];
  len_vec_t lv[8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Latency table: length 4, words 0x00010002 and 0x00030004, ready=1
    hv[0] = '{1'b1, 32'h0001_0002, 1'b1, 1'b0, 16'h0, 1'b0};
    hv[1] = '{1'b1, 32'h0003_0004, 1'b0, 1'b1, 16'h1, 1'b0};
    hv[2] = '{1'b1, 32'h0003_0004, 1'b1, 1'b1, 16'h2, 1'b0};
    hv[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 16'h3, 1'b0};
    hv[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 16'h4, 1'b1};
    hv[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 16'h0, 1'b0};

    lv[0] = '{8'd130, 32'd4,          4};
    lv[1] = '{8'd130, 32'd7,          6};
    lv[2] = '{8'd130, 32'd0,          6};
    lv[3] = '{8'd130, 32'd2000,      64};
    lv[4] = '{8'd131, 32'd10,        64};
    lv[5] = '{8'd130, 32'd2,          2};
    lv[6] = '{8'd130, 32'd65,        64};
    lv[7] = '{8'd130, 32'h0001_0008,  8};

    repeat (3) @(posedge ce_clk);
    #1;
    do_reset();

    // Reset state
    @(negedge ce_clk);
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", {16'd0, m_axis_tdata}, 32'd0);
    check("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("rst_s_ready", {31'd0, s_axis_tready}, 32'd1);
    check("rst_frames", frame_count, 32'd0);
    check("rst_mismatch", {16'd0, mismatch_count}, 32'd0);
    @(posedge ce_clk); #1;

    // Hand sequence: first sample one cycle after accept
    write_reg(8'(SR_FRAME_LEN), 32'd4);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_axis_tvalid = hv[k].sv;
      s_axis_tdata  = hv[k].sd;
      s_axis_tlast  = 1'b0;
      @(negedge ce_clk);
      check("lat_s_ready", {31'd0, s_axis_tready}, {31'd0, hv[k].e_srdy});
      check("lat_tvalid", {31'd0, m_axis_tvalid}, {31'd0, hv[k].e_vld});
      if (hv[k].e_vld) begin
        check("lat_tdata", {16'd0, m_axis_tdata}, {16'd0, hv[k].e_d});
        check("lat_tlast", {31'd0, m_axis_tlast}, {31'd0, hv[k].e_l});
      end
      @(posedge ce_clk); #1;
    end
    s_axis_tvalid = 1'b0;
    check("lat_frames", frame_count, 32'd1);

    // Stalls with ready toggling 1010...
    do_reset();
    write_reg(8'(SR_FRAME_LEN), 32'd4);
    m_pend = 4;
    for (int i = 0; i < 8; i++) queue_word($urandom, 1'b0);
    tog = 1'b1;
    run_stream(1, 1'b0);

    // Length change mid-vector takes effect on the next vector
    do_reset();
    write_reg(8'(SR_FRAME_LEN), 32'd4);
    m_pend = 4;
    queue_word(32'h0101_0202, 1'b0);
    run_stream(0, 1'b0);
    write_reg(8'(SR_FRAME_LEN), 32'd6);
    m_pend = 6;
    for (int i = 0; i < 4; i++) queue_word($urandom, 1'b0);
    run_stream(0, 1'b0);

    // Length register table
    do_reset();
    for (int v = 0; v < 8; v++) begin
      write_reg(lv[v].addr, lv[v].data);
      m_pend = lv[v].exp_len;
      for (int i = 0; i < lv[v].exp_len / 2; i++) queue_word($urandom, 1'b0);
      run_stream(0, 1'b0);
    end

    // Upstream packet ending mid-vector (padding or continuous framing)
    do_reset();
    write_reg(8'(SR_FRAME_LEN), 32'd8);
    m_pend = 8;
    queue_word(32'h0011_0012, 1'b0);
    queue_word(32'h0013_0014, 1'b1);
    queue_word(32'h0015_0016, 1'b0);
    queue_word(32'h0017_0018, 1'b0);
    run_stream(0, 1'b0);

    // Reset mid-vector
    s_axis_tdata = 32'h0021_0022; s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    @(posedge ce_clk); #1;
    s_axis_tvalid = 1'b0;
    @(posedge ce_clk); #1;
    ce_rst = 1'b1; m_axis_tready = 1'b0;
    @(posedge ce_clk); #1;
    ce_rst = 1'b0;
    @(negedge ce_clk);
    check("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("midrst_tdata", {16'd0, m_axis_tdata}, 32'd0);
    check("midrst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check("midrst_s_ready", {31'd0, s_axis_tready}, 32'd1);
    check("midrst_frames", frame_count, 32'd0);
    check("midrst_mismatch", {16'd0, mismatch_count}, 32'd0);
    @(posedge ce_clk); #1;
    model_reset();
    // Length back at its maximum, counter restarted from 0
    for (int i = 0; i < FRAME_LEN_MAX / 2; i++) queue_word($urandom, 1'b0);
    run_stream(0, 1'b0);
    write_reg(8'(SR_FRAME_LEN), 32'd4);
    m_pend = 4;
    queue_word(32'h0031_0032, 1'b0);
    queue_word(32'h0033_0034, 1'b0);
    run_stream(0, 1'b0);

    // Randomized streams with random lengths, packet ends, stalls and gaps
    do_reset();
    for (int b = 0; b < 10; b++) begin
      int len;
      len = 2 * $urandom_range(1, FRAME_LEN_MAX / 2);
      write_reg(8'(SR_FRAME_LEN), 32'(len + $urandom_range(0, 1)));
      m_pend = len;
      for (int i = 0; i < 20; i++) queue_word($urandom, ($urandom_range(0, 3) == 0));
      run_stream(2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
